// File: rtl/hud_pkg.sv
// Shared HUD types: colour constants, bar state enum, rgb type and a counter-width helper.
package hud_pkg;

  typedef logic [11:0] hud_rgb_t;

  localparam hud_rgb_t HUD_LIT   = 12'h0F0;
  localparam hud_rgb_t HUD_LOW   = 12'hF80;
  localparam hud_rgb_t HUD_GHOST = 12'hFF0;
  localparam hud_rgb_t HUD_FLASH = 12'hFFF;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } hud_state_e;

  // Bits needed to hold values 0..n (at least one bit).
  function automatic int unsigned hud_cnt_w(input int unsigned n);
    return (n == 0) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/health_bar_renderer_if.sv
// Pixel-side bus of one health bar: coordinate/health/frame pulse in, pixel enable/colour out.
interface health_bar_renderer_if #(
  parameter int unsigned HP_W = 4
);
  logic [9:0]        x;
  logic [9:0]        y;
  logic [HP_W-1:0]   hp;
  logic              frame_tick;
  logic              pix_en;
  hud_pkg::hud_rgb_t pix_rgb;

  modport master (output x, y, hp, frame_tick, input pix_en, pix_rgb);
  modport slave  (input x, y, hp, frame_tick, output pix_en, pix_rgb);
endinterface

// File: rtl/hud_seg_locator.sv
// Combinational pixel-to-segment locator: in-bar flag and segment index via parallel range compares.
module hud_seg_locator
  import hud_pkg::*;
#(
  parameter  int unsigned SEGMENTS = 8,
  parameter  int unsigned SEG_W    = 25,
  parameter  int unsigned BAR_X0   = 400,
  parameter  int unsigned BAR_Y0   = 10,
  parameter  int unsigned BAR_H    = 11,
  localparam int unsigned IDX_W    = hud_cnt_w(SEGMENTS)
) (
  input  logic [9:0]       x_i,
  input  logic [9:0]       y_i,
  output logic             in_bar_c_o,
  output logic [IDX_W-1:0] seg_idx_c_o
);

  logic [31:0] x_w;
  logic [31:0] y_w;
  logic        any_seg;
  logic        in_rows;

  assign x_w = 32'(x_i);
  assign y_w = 32'(y_i);
  assign in_rows = (y_w >= BAR_Y0) && (y_w < BAR_Y0 + BAR_H);

  // Half-open column windows never overlap, so OR-ing matching indices yields the one hit.
  always_comb begin
    any_seg     = 1'b0;
    seg_idx_c_o = '0;
    for (int unsigned i = 0; i < SEGMENTS; i++) begin
      if ((x_w >= BAR_X0 + i * SEG_W) && (x_w < BAR_X0 + (i + 1) * SEG_W)) begin
        any_seg     = 1'b1;
        seg_idx_c_o = seg_idx_c_o | IDX_W'(i);
      end
    end
  end

  assign in_bar_c_o = any_seg && in_rows;

endmodule

// File: rtl/health_bar_renderer.sv
// Animated health-bar pixel generator: lit/ghost segments, hit flash, low-health colour.
// Optional HEALTH_LOW_BLINK_EN blanks lit segments in alternate 16-frame phases at low health.
module health_bar_renderer
  import hud_pkg::*;
#(
  parameter int unsigned SEGMENTS     = 8,
  parameter int unsigned HP_W         = 4,
  parameter int unsigned SEG_W        = 25,
  parameter int unsigned BAR_X0       = 400,
  parameter int unsigned BAR_Y0       = 10,
  parameter int unsigned BAR_H        = 11,
  parameter int unsigned DRAIN_FRAMES = 4,
  parameter int unsigned FLASH_FRAMES = 8,
  parameter int unsigned LOW_HP       = 2
) (
  input logic                   clk,
  input logic                   rst,
  health_bar_renderer_if.slave  bus
);

  localparam int unsigned CNT_W   = hud_cnt_w(SEGMENTS);
  localparam int unsigned DRAIN_W = hud_cnt_w(DRAIN_FRAMES - 1);
  localparam int unsigned FL_W0   = hud_cnt_w(FLASH_FRAMES);
  localparam int unsigned FLASH_W = (FL_W0 < 2) ? 2 : FL_W0;
  localparam int unsigned LOW_LIM = (LOW_HP > SEGMENTS) ? SEGMENTS : LOW_HP;

  logic [HP_W-1:0]    hp_in;
  logic [31:0]        hp_w;
  logic [CNT_W-1:0]   hp_c;
  logic               in_bar;
  logic [CNT_W-1:0]   seg_idx;

  hud_state_e         state_q,  state_d;
  logic [CNT_W-1:0]   hp_q,     hp_d;
  logic [CNT_W-1:0]   ghost_q,  ghost_d;
  logic [FLASH_W-1:0] flash_q,  flash_d;
  logic [DRAIN_W-1:0] drain_q,  drain_d;
  logic               pix_en_q, pix_en_d;
  hud_rgb_t           pix_rgb_q, pix_rgb_d;

  logic lit_px, ghost_px, low_hp, flash_on, lit_vis;

  assign hp_in = bus.hp;
  assign hp_w  = 32'(hp_in);
  assign hp_c  = (hp_w > SEGMENTS) ? CNT_W'(SEGMENTS) : CNT_W'(hp_w);

  hud_seg_locator #(
    .SEGMENTS (SEGMENTS),
    .SEG_W    (SEG_W),
    .BAR_X0   (BAR_X0),
    .BAR_Y0   (BAR_Y0),
    .BAR_H    (BAR_H)
  ) u_loc (
    .x_i         (bus.x),
    .y_i         (bus.y),
    .in_bar_c_o  (in_bar),
    .seg_idx_c_o (seg_idx)
  );

  assign lit_px   = in_bar && (seg_idx < hp_c);
  assign ghost_px = in_bar && !lit_px && (seg_idx < ghost_q);
  assign low_hp   = (hp_c != '0) && (hp_c <= CNT_W'(LOW_LIM));
  assign flash_on = (flash_q != '0) && flash_q[1];

`ifdef HEALTH_LOW_BLINK_EN
  logic [4:0] blink_q, blink_d;
  assign blink_d = bus.frame_tick ? blink_q + 5'd1 : blink_q;
  assign lit_vis = lit_px && !(low_hp && blink_q[4]);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) blink_q <= '0;
    else      blink_q <= blink_d;
  end
`else
  assign lit_vis = lit_px;
`endif

  // Pixel class to colour; flash overrides both normal and low lit colours.
  always_comb begin
    pix_en_d  = lit_vis || ghost_px;
    pix_rgb_d = '0;
    if (lit_vis) begin
      if (flash_on)    pix_rgb_d = HUD_FLASH;
      else if (low_hp) pix_rgb_d = HUD_LOW;
      else             pix_rgb_d = HUD_LIT;
    end else if (ghost_px) begin
      pix_rgb_d = HUD_GHOST;
    end
  end

  // Ghost/flash control; a hit outranks the same-cycle frame tick.
  always_comb begin
    state_d = state_q;
    hp_d    = hp_c;
    ghost_d = ghost_q;
    flash_d = flash_q;
    drain_d = drain_q;
    if (bus.frame_tick && (flash_q != '0)) flash_d = flash_q - FLASH_W'(1);
    if (hp_c < hp_q) begin
      flash_d = FLASH_W'(FLASH_FRAMES);
      drain_d = '0;
      state_d = DRAIN;
    end else if ((hp_c > hp_q) && (hp_c >= ghost_q)) begin
      ghost_d = hp_c;
      state_d = IDLE;
    end else if ((state_q == DRAIN) && bus.frame_tick) begin
      if (drain_q == DRAIN_W'(DRAIN_FRAMES - 1)) begin
        drain_d = '0;
        if (ghost_q > hp_c) ghost_d = ghost_q - CNT_W'(1);
      end else begin
        drain_d = drain_q + DRAIN_W'(1);
      end
      if (ghost_d <= hp_c) begin
        ghost_d = hp_c;
        state_d = IDLE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      hp_q      <= CNT_W'(SEGMENTS);
      ghost_q   <= CNT_W'(SEGMENTS);
      flash_q   <= '0;
      drain_q   <= '0;
      pix_en_q  <= 1'b0;
      pix_rgb_q <= '0;
    end else begin
      state_q   <= state_d;
      hp_q      <= hp_d;
      ghost_q   <= ghost_d;
      flash_q   <= flash_d;
      drain_q   <= drain_d;
      pix_en_q  <= pix_en_d;
      pix_rgb_q <= pix_rgb_d;
    end
  end

  assign bus.pix_en  = pix_en_q;
  assign bus.pix_rgb = pix_rgb_q;

endmodule

// File: tb/tb_health_bar_renderer.sv
// Randomized self-checking bench for health_bar_renderer against a frame-level behavioural model.
module tb_health_bar_renderer;

  localparam int SEGMENTS = 8;
  localparam int SEG_W    = 25;
  localparam int X0       = 400;
  localparam int Y0       = 10;
  localparam int BAR_H    = 11;
  localparam int DRAIN_FR = 4;
  localparam int FLASH_FR = 8;
  localparam int LOW_HP   = 2;

  logic clk;
  logic rst;
  int   n_total = 0;
  int   n_bad   = 0;

  // model state
  int m_hpq, m_ghost, m_flash, m_ticks, m_blink;
  bit m_draining;

  health_bar_renderer_if #(.HP_W(4)) bus ();

  health_bar_renderer #(
    .SEGMENTS(8), .HP_W(4), .SEG_W(25), .BAR_X0(400), .BAR_Y0(10), .BAR_H(11),
    .DRAIN_FRAMES(4), .FLASH_FRAMES(8), .LOW_HP(2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic void model_reset();
    m_hpq = SEGMENTS; m_ghost = SEGMENTS; m_flash = 0; m_ticks = 0; m_blink = 0;
    m_draining = 1'b0;
  endfunction

  function automatic int clamp_hp(input int hp);
    return (hp > SEGMENTS) ? SEGMENTS : hp;
  endfunction

  // One clock of frame-level behaviour: damage, healing, flash and ghost drain.
  function automatic void model_update(input int hc, input bit tick);
    if (hc < m_hpq) m_flash = FLASH_FR;
    else if (tick && m_flash > 0) m_flash = m_flash - 1;
    if (hc < m_hpq) begin
      m_draining = 1'b1;
      m_ticks = 0;
    end else if (hc > m_hpq && hc >= m_ghost) begin
      m_ghost = hc;
      m_draining = 1'b0;
    end else if (m_draining && tick) begin
      m_ticks = m_ticks + 1;
      if (m_ticks == DRAIN_FR) begin
        m_ticks = 0;
        if (m_ghost > hc) m_ghost = m_ghost - 1;
      end
      if (m_ghost <= hc) begin
        m_ghost = hc;
        m_draining = 1'b0;
      end
    end
    if (tick) m_blink = (m_blink + 1) % 32;
    m_hpq = hc;
  endfunction

  task automatic step(input bit tick);
    int hc, seg, e_en, e_rgb;
    bit inb, lit, gh, low, blank;
    hc  = clamp_hp(int'(bus.hp));
    inb = int'(bus.x) >= X0 && int'(bus.x) < X0 + SEGMENTS * SEG_W &&
          int'(bus.y) >= Y0 && int'(bus.y) < Y0 + BAR_H;
    seg = inb ? (int'(bus.x) - X0) / SEG_W : SEGMENTS;
    lit = inb && seg < hc;
    gh  = inb && !lit && seg < m_ghost;
    low = hc > 0 && hc <= LOW_HP;
`ifdef HEALTH_LOW_BLINK_EN
    blank = low && m_blink >= 16;
`else
    blank = 1'b0;
`endif
    e_en  = ((lit && !blank) || gh) ? 1 : 0;
    e_rgb = 0;
    if (lit && !blank) begin
      if (m_flash != 0 && (m_flash / 2) % 2 == 1) e_rgb = 'hFFF;
      else if (low)                               e_rgb = 'hF80;
      else                                        e_rgb = 'h0F0;
    end else if (gh) e_rgb = 'hFF0;
    bus.frame_tick = tick;
    @(posedge clk);
    model_update(hc, tick);
    #1;
    check("pix_en", 32'(bus.pix_en), e_en);
    if (e_en == 1) check("pix_rgb", 32'(bus.pix_rgb), e_rgb);
    bus.frame_tick = 1'b0;
  endtask

  task automatic probe(input string tag, input int px, input int py, input int e_en, input int e_rgb);
    bus.x = 10'(px);
    bus.y = 10'(py);
    step(1'b0);
    check({tag, "_en"}, 32'(bus.pix_en), e_en);
    if (e_en == 1) check({tag, "_rgb"}, 32'(bus.pix_rgb), e_rgb);
  endtask

  task automatic rand_pix();
    bus.x = 10'(X0 + $urandom_range(0, SEGMENTS * SEG_W - 1));
    bus.y = 10'(Y0 + $urandom_range(0, BAR_H - 1));
  endtask

  task automatic run_ticks(input int n);
    for (int k = 0; k < n; k++) begin
      for (int c = 0; c < 3; c++) begin
        rand_pix();
        step(1'b0);
      end
      rand_pix();
      step(1'b1);
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.x = '0; bus.y = '0; bus.hp = 4'd8; bus.frame_tick = 1'b0;
    #1 rst = 1'b0;
    #2;
    check("rst_en", 32'(bus.pix_en), 0);
    check("rst_rgb", 32'(bus.pix_rgb), 0);
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b1;

    // full bar scan
    bus.y = 10'd10;
    for (int px = X0; px < X0 + SEGMENTS * SEG_W; px++) begin
      bus.x = 10'(px);
      step(1'b0);
    end
    probe("scan_end", 599, 10, 1, 'h0F0);
    probe("off_x", 600, 10, 0, 0);
    bus.x = 10'd400;
    #1 check("latency", 32'(bus.pix_en), 0);
    probe("on_x", 400, 20, 1, 'h0F0);
    probe("off_y", 400, 21, 0, 0);

    // hit 8 -> 5 and drain
    bus.hp = 4'd5;
    probe("hit_pre", 400, 10, 1, 'h0F0);
    run_ticks(1);
    probe("flash", 400, 10, 1, 'hFFF);
    run_ticks(3);
    probe("g7_s7", 575, 10, 0, 0);
    probe("g7_s6", 550, 10, 1, 'hFF0);
    run_ticks(4);
    probe("g6_s6", 550, 10, 0, 0);
    probe("g6_s5", 525, 10, 1, 'hFF0);
    run_ticks(4);
    probe("g5_s5", 525, 10, 0, 0);
    probe("g5_s4", 500, 10, 1, 'h0F0);

    // re-hit mid-drain
    bus.hp = 4'd8;
    probe("heal8", 575, 10, 1, 'h0F0);
    bus.hp = 4'd5;
    run_ticks(6);
    bus.hp = 4'd3;
    probe("rehit", 550, 10, 1, 'hFF0);
    run_ticks(15);
    probe("rh_g4", 475, 10, 1, 'hFF0);
    run_ticks(1);
    probe("rh_g3", 475, 10, 0, 0);

    // heal above ghost mid-drain, then low colour
    bus.hp = 4'd8;
    step(1'b0);
    bus.hp = 4'd4;
    run_ticks(8);
    bus.hp = 4'd7;
    probe("heal7_s6", 550, 10, 1, 'h0F0);
    probe("heal7_s7", 575, 10, 0, 0);
    bus.hp = 4'd2;
    probe("low", 400, 10, 1, 'hF80);

    // clamp and full drain to zero
    bus.hp = 4'd15;
    probe("clamp", 575, 10, 1, 'h0F0);
    bus.hp = 4'd0;
    run_ticks(31);
    probe("z_g1", 400, 10, 1, 'hFF0);
    run_ticks(1);
    probe("z_g0", 400, 10, 0, 0);

    // reset mid-drain
    bus.hp = 4'd8;
    step(1'b0);
    bus.hp = 4'd4;
    run_ticks(5);
    bus.x = 10'd400; bus.y = 10'd10;
    @(posedge clk);
    #3 rst = 1'b0;
    #1 check("rst_async", 32'(bus.pix_en), 0);
    model_reset();
    bus.hp = 4'd8;
    @(negedge clk) rst = 1'b1;
    probe("post_rst_s7", 575, 10, 1, 'h0F0);
    probe("post_rst_s5", 525, 10, 1, 'h0F0);

`ifdef HEALTH_LOW_BLINK_EN
    bus.hp = 4'd1;
    run_ticks(40);
`endif

    // random soak
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 39) == 0) bus.hp = 4'($urandom_range(0, 15));
      bus.x = 10'($urandom_range(390, 610));
      bus.y = 10'($urandom_range(5, 25));
      step($urandom_range(0, 7) == 0);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/health_bar_renderer.md
Name: health_bar_renderer

Overview:
- Parametrised, animated health-bar pixel generator for the VGA overlay. Replaces the fixed per-segment enable approach.
- Takes the current pixel coordinate and a health value, and emits one registered pixel-enable plus a 12-bit colour.
- Adds behaviour that fixed segment enables cannot provide:
  - a "ghost" segment trail that drains slowly after damage;
  - a white hit-flash;
  - a low-health colour.
- One instance is used per bar: player, boss, and so on.

Parameters:
- SEGMENTS, 8: number of bar segments (1..15).
- HP_W, 4: width of the health input.
- SEG_W, 25: segment width in pixels.
- BAR_X0, 400: left pixel column of segment 0.
- BAR_Y0, 10: top pixel row of the bar.
- BAR_H, 11: bar height in pixels.
- DRAIN_FRAMES, 4: frames per ghost-segment decrement.
- FLASH_FRAMES, 8: hit-flash duration in frames.
- LOW_HP, 2: health at or below this value (and above 0) uses the low colour.

Ports:
- clk, in, 1: pixel clock.
- rst, in, 1: asynchronous, active-low reset.
- x, in, 10: current pixel column.
- y, in, 10: current pixel row.
- hp, in, HP_W: present health. Values above SEGMENTS are clamped to SEGMENTS.
- frame_tick, in, 1: single-cycle pulse once per frame (start of vblank).
- pix_en, out, 1: this pixel belongs to a lit or ghost segment.
- pix_rgb, out, 12: colour for the pixel; valid when pix_en=1.

Behaviour:
- Reset (rst=0, asynchronous):
  - pix_en=0 and pix_rgb=12'h000.
  - hp_q=SEGMENTS, ghost=SEGMENTS, flash_cnt=0, drain_cnt=0.
  - State is IDLE.
- Clamping: hp_c = min(hp, SEGMENTS).
- Geometry:
  - Segment i (0-based) covers x in [BAR_X0+i*SEG_W, BAR_X0+(i+1)*SEG_W) and y in [BAR_Y0, BAR_Y0+BAR_H). Both ranges are half-open, so segments never overlap.
  - The segment index is found with SEGMENTS parallel compares. No divider is used.
- Pixel class for segment i:
  - i < hp_c: lit.
  - hp_c <= i < ghost: ghost.
  - otherwise, or outside the bar: off.
- Colours:
  - lit: 12'h0F0, or 12'hF80 when 0 < hp_c <= LOW_HP.
  - ghost: 12'hFF0.
  - Flash override: while flash_cnt != 0 and flash_cnt[1] == 1, lit pixels are 12'hFFF.
- Latency: pix_en and pix_rgb are registered, giving exactly 1 clk of latency from x/y/hp.
- hp_q is a per-clock register of hp_c.
- Hit detection (hp_c < hp_q):
  - flash_cnt loads FLASH_FRAMES and drain_cnt loads 0.
  - State goes to DRAIN. ghost is unchanged, so it keeps the higher old value.
- Heal (hp_c > hp_q): if hp_c >= ghost, ghost takes hp_c immediately and state goes to IDLE.
- State machine:
  - IDLE: ghost == hp_c. Nothing decrements.
  - DRAIN, on each frame_tick:
    - drain_cnt increments.
    - When drain_cnt reaches DRAIN_FRAMES-1, drain_cnt goes to 0 and ghost decrements by 1.
    - When ghost == hp_c after the decrement, state goes to IDLE.
  - ghost never falls below hp_c, and never exceeds SEGMENTS.
- flash_cnt decrements by 1 on each frame_tick while non-zero, saturating at 0.
- Simultaneous events:
  - A hit in the same clk as frame_tick: the hit's load wins for both flash_cnt and drain_cnt.
  - A hit during DRAIN restarts the flash and drain_cnt; ghost is held.
- hp = 0: nothing is lit. The ghost drains to 0.
- Reset mid-drain: returns immediately to the reset values above.

Optional Feature:
- Macro: HEALTH_LOW_BLINK_EN.
- Defined: while 0 < hp_c <= LOW_HP, lit segments are blanked (pix_en=0) in alternate 16-frame phases.
  - A 5-bit blink_cnt advances on frame_tick; blanking applies when blink_cnt[4] == 1.
  - blink_cnt resets to 0.
- Not defined: no blanking, no blink_cnt; the low colour is static.

Decomposition:
- Shared package hud_pkg holds:
  - colour constants: HUD_LIT, HUD_LOW, HUD_GHOST, HUD_FLASH;
  - the state enum {IDLE, DRAIN};
  - the 12-bit rgb typedef.
- One natural sub-module, hud_seg_locator: combinational x/y to in_bar flag and segment index.
  - Parametrised by SEGMENTS, SEG_W, BAR_X0, BAR_Y0, BAR_H.
  - Reusable by future HUD elements.

Test Plan (defaults unless noted):
- Reset, hp=8, scan (x=400..599, y=10): pix_en=1 on all 200 pixels, rgb=12'h0F0.
  - x=600 or y=21: pix_en=0.
  - Output appears 1 clk after the coordinate.
- hp 8->5 with frame_tick pulsed:
  - Segments 5..7 show 12'hFF0.
  - ghost goes 8->7 after 4 ticks, 7->6 after 8 ticks, 6->5 after 12 ticks.
  - State then returns to IDLE. Lit pixels are 12'hFFF on flash phases during the first 8 ticks.
- hp 8->5, then 5->3 at tick 6 (ghost=7): ghost stays 7, the flash restarts, and the drain reaches 3 after 16 further ticks.
- hp 8->4, then hp=7 mid-drain with ghost=6: ghost becomes 7 the next clk and state goes to IDLE. Then hp=2: lit colour is 12'hF80.
- hp=15 with SEGMENTS=8: clamps to 8, all segments lit. Then hp=0: no lit pixels, and the ghost drains 8->0 in 32 ticks.
- Assert rst during DRAIN: pix_en=0 asynchronously. On release, the bar shows full with no ghost.
  - With HEALTH_LOW_BLINK_EN and hp=1: segment 0 is blanked on ticks 16..31.
